// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and the RAM controller's write/read FSM state encodings.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_ram_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous byte-enabled write port, one synchronous read port, no reset.
module axi4_lite_ram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A read on the same edge as a write to the same word returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axi4_lite_ram_ctrl.sv
// AXI4-Lite slave in front of a single-ported-per-direction RAM; independent read and write paths.
// Optional AXI4_LITE_RAM_PROT_EN: unprivileged writes (AWPROT[0]=0) are rejected with SLVERR.
module axi4_lite_ram_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      s_AWVALID,
    input  logic [2:0]                s_AWPROT,
    input  logic [ADDR_WIDTH-1:0]     s_AWADDR,
    output logic                      s_AWREADY,
    input  logic                      s_WVALID,
    input  logic [DATA_WIDTH-1:0]     s_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   s_WSTRB,
    output logic                      s_WREADY,
    input  logic                      s_BREADY,
    output logic                      s_BVALID,
    output logic [1:0]                s_BRESP,
    input  logic                      s_ARVALID,
    input  logic [2:0]                s_ARPROT,
    input  logic [ADDR_WIDTH-1:0]     s_ARADDR,
    output logic                      s_ARREADY,
    input  logic                      s_RREADY,
    output logic                      s_RVALID,
    output logic [1:0]                s_RRESP,
    output logic [DATA_WIDTH-1:0]     s_RDATA
);

    import axi4_lite_pkg::*;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    wr_state_t               wr_state;
    logic                    aw_held;
    logic                    w_held;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic                    aw_fire;
    logic                    w_fire;
    logic [ADDR_WIDTH:0]     aw_diff;
    logic                    aw_ok;
    logic [1:0]              wr_resp;
    logic                    wr_en;

    rd_state_t               rd_state;
    logic                    ar_fire;
    logic [ADDR_WIDTH:0]     ar_diff;
    logic                    ar_ok;
    logic [DATA_WIDTH-1:0]   rd_q;

`ifdef AXI4_LITE_RAM_PROT_EN
    logic [2:0]              aw_prot;
    logic                    unused_prot;
    assign unused_prot = ^s_ARPROT;
`else
    logic                    unused_prot;
    assign unused_prot = ^{s_AWPROT, s_ARPROT};
`endif

    // Borrow bit of the subtraction flags addresses below BASE_ADDR.
    assign aw_diff = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
    assign aw_ok   = ~aw_diff[ADDR_WIDTH] && ((aw_diff[ADDR_WIDTH-1:0] >> (OFFS + IDX_W)) == '0);
    assign ar_diff = {1'b0, s_ARADDR} - {1'b0, BASE_ADDR};
    assign ar_ok   = ~ar_diff[ADDR_WIDTH] && ((ar_diff[ADDR_WIDTH-1:0] >> (OFFS + IDX_W)) == '0);

    assign s_AWREADY = ~iRST & ~aw_held & ~s_BVALID;
    assign s_WREADY  = ~iRST & ~w_held & ~s_BVALID;
    assign aw_fire   = s_AWVALID & s_AWREADY;
    assign w_fire    = s_WVALID & s_WREADY;

    always_comb begin
        wr_resp = RESP_OKAY;
        if (!aw_ok) begin
            wr_resp = RESP_DECERR;
        end
`ifdef AXI4_LITE_RAM_PROT_EN
        else if (!aw_prot[0]) begin
            wr_resp = RESP_SLVERR;
        end
`endif
    end

    assign wr_en = (wr_state == W_COMMIT) && (wr_resp == RESP_OKAY);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            s_BVALID <= 1'b0;
            s_BRESP  <= RESP_OKAY;
`ifdef AXI4_LITE_RAM_PROT_EN
            aw_prot  <= '0;
`endif
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= s_AWADDR;
`ifdef AXI4_LITE_RAM_PROT_EN
                aw_prot <= s_AWPROT;
`endif
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= s_WDATA;
                w_strb <= s_WSTRB;
            end
            case (wr_state)
                W_IDLE, W_HAVE_A, W_HAVE_D: begin
                    if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                        wr_state <= W_COMMIT;
                    end else if (aw_held || aw_fire) begin
                        wr_state <= W_HAVE_A;
                    end else if (w_held || w_fire) begin
                        wr_state <= W_HAVE_D;
                    end
                end
                W_COMMIT: begin
                    wr_state <= W_RESP;
                    aw_held  <= 1'b0;
                    w_held   <= 1'b0;
                    s_BVALID <= 1'b1;
                    s_BRESP  <= wr_resp;
                end
                W_RESP: begin
                    if (s_BREADY) begin
                        wr_state <= W_IDLE;
                        s_BVALID <= 1'b0;
                        s_BRESP  <= RESP_OKAY;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign s_ARREADY = ~iRST & ~s_RVALID;
    assign ar_fire   = s_ARVALID & s_ARREADY;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rd_state <= R_IDLE;
            s_RVALID <= 1'b0;
            s_RRESP  <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rd_state <= R_VALID;
                        s_RVALID <= 1'b1;
                        s_RRESP  <= ar_ok ? RESP_OKAY : RESP_DECERR;
                    end
                end
                R_VALID: begin
                    if (s_RREADY) begin
                        rd_state <= R_IDLE;
                        s_RVALID <= 1'b0;
                        s_RRESP  <= RESP_OKAY;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // rd_q only changes on an accepted in-range read, so the beat stays stable while stalled.
    assign s_RDATA = (s_RVALID && (s_RRESP == RESP_OKAY)) ? rd_q : '0;

    axi4_lite_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (iCLK),
        .wr_en   (wr_en),
        .wr_idx  (aw_diff[OFFS +: IDX_W]),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_en   (ar_fire && ar_ok),
        .rd_idx  (ar_diff[OFFS +: IDX_W]),
        .rd_data (rd_q)
    );

endmodule

// File: tb/tb_axi4_lite_ram_ctrl.sv
// Randomized self-checking bench for axi4_lite_ram_ctrl against a word-array reference model.
// Builds with or without AXI4_LITE_RAM_PROT_EN.
module tb_axi4_lite_ram_ctrl;

    localparam int DEPTH = 1024;
    localparam logic [31:0] MEM_BYTES = 32'h0000_1000;
`ifdef AXI4_LITE_RAM_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_AWVALID, s_AWREADY, s_WVALID, s_WREADY;
    logic [2:0]  s_AWPROT, s_ARPROT;
    logic [31:0] s_AWADDR, s_ARADDR, s_WDATA, s_RDATA;
    logic [3:0]  s_WSTRB;
    logic        s_BREADY, s_BVALID, s_ARVALID, s_ARREADY, s_RREADY, s_RVALID;
    logic [1:0]  s_BRESP, s_RRESP;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    always #5 clk = ~clk;

    axi4_lite_ram_ctrl dut (
        .iCLK      (clk),
        .iRST      (rst),
        .s_AWVALID (s_AWVALID),
        .s_AWPROT  (s_AWPROT),
        .s_AWADDR  (s_AWADDR),
        .s_AWREADY (s_AWREADY),
        .s_WVALID  (s_WVALID),
        .s_WDATA   (s_WDATA),
        .s_WSTRB   (s_WSTRB),
        .s_WREADY  (s_WREADY),
        .s_BREADY  (s_BREADY),
        .s_BVALID  (s_BVALID),
        .s_BRESP   (s_BRESP),
        .s_ARVALID (s_ARVALID),
        .s_ARPROT  (s_ARPROT),
        .s_ARADDR  (s_ARADDR),
        .s_ARREADY (s_ARREADY),
        .s_RREADY  (s_RREADY),
        .s_RVALID  (s_RVALID),
        .s_RRESP   (s_RRESP),
        .s_RDATA   (s_RDATA)
    );

    // Reference model: BASE_ADDR=0, 4-byte words, 1024 words => valid bytes 0x0..0xFFF.
    function automatic logic [1:0] exp_wresp(input logic [31:0] addr, input logic [2:0] prot);
        if (addr >= MEM_BYTES) return 2'b11;
        if (PROT_EN && !prot[0]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, input logic [2:0] prot);
        int idx;
        if (exp_wresp(addr, prot) != 2'b00) return;
        idx = int'(addr / 4);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) ref_mem[idx][8*i +: 8] = data[8*i +: 8];
        end
        if (strb == 4'hF) ref_known[idx] = 1'b1;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int aw_delay, input int w_delay,
                             output logic [1:0] resp, output int b_lat);
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        bit aw_hs, w_hs;
        int cyc = 0;
        resp  = 2'b01;
        b_lat = -1;
        while ((aw_pend || w_pend) && cyc < 200) begin
            if (aw_pend && cyc >= aw_delay) begin
                s_AWVALID = 1'b1; s_AWADDR = addr; s_AWPROT = prot;
            end
            if (w_pend && cyc >= w_delay) begin
                s_WVALID = 1'b1; s_WDATA = data; s_WSTRB = strb;
            end
            aw_hs = s_AWVALID && s_AWREADY;
            w_hs  = s_WVALID && s_WREADY;
            @(posedge clk); #1;
            if (aw_hs) begin aw_pend = 1'b0; s_AWVALID = 1'b0; end
            if (w_hs)  begin w_pend  = 1'b0; s_WVALID  = 1'b0; end
            cyc++;
        end
        total++;
        if (aw_pend || w_pend) begin
            bad++;
            $display("[TB] FAIL write_handshake addr=%h: pending aw=%0b w=%0b, required 0 0", addr, aw_pend, w_pend);
            s_AWVALID = 1'b0; s_WVALID = 1'b0;
        end
        s_BREADY = 1'b1;
        b_lat = 0;
        while (!s_BVALID && b_lat < 200) begin
            @(posedge clk); #1;
            b_lat++;
        end
        total++;
        if (!s_BVALID) begin
            bad++;
            $display("[TB] FAIL write_bvalid_timeout addr=%h: bvalid=%b, required 1", addr, s_BVALID);
        end else begin
            resp = s_BRESP;
            @(posedge clk); #1;
        end
        s_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int r_lat);
        int cyc = 0;
        s_ARVALID = 1'b1; s_ARADDR = addr; s_ARPROT = 3'($urandom_range(0, 7)); s_RREADY = 1'b1;
        while (!s_ARREADY && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        s_ARVALID = 1'b0;
        r_lat = 0;
        while (!s_RVALID && r_lat < 200) begin
            @(posedge clk); #1;
            r_lat++;
        end
        total++;
        if (!s_RVALID) begin
            bad++;
            $display("[TB] FAIL read_rvalid_timeout addr=%h: rvalid=%b, required 1", addr, s_RVALID);
        end
        data = s_RDATA;
        resp = s_RRESP;
        @(posedge clk); #1;
        s_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b1;
        s_AWVALID = 0; s_AWPROT = 0; s_AWADDR = 0; s_WVALID = 0; s_WDATA = 0; s_WSTRB = 0;
        s_BREADY = 0; s_ARVALID = 0; s_ARPROT = 0; s_ARADDR = 0; s_RREADY = 0;
        repeat (2) @(posedge clk);
        #1;
        obs = {s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID};
        total++;
        if (obs !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_flags: got %b, required 00000", obs);
        end
        total++;
        if ({s_BRESP, s_RRESP, s_RDATA} !== 36'h0) begin
            bad++; $display("[TB] FAIL reset_data: got %h %h %h, required 0 0 0", s_BRESP, s_RRESP, s_RDATA);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({s_AWREADY, s_WREADY, s_ARREADY} !== 3'b111) begin
            bad++; $display("[TB] FAIL ready_after_reset: got %b, required 111", {s_AWREADY, s_WREADY, s_ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] data; int lat;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, resp, lat);
        model_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b001);
        total++;
        if (resp !== 2'b00) begin bad++; $display("[TB] FAIL basic_bresp: got %b, required 00", resp); end
        total++;
        if (lat != 1) begin bad++; $display("[TB] FAIL basic_b_latency: got %0d, required 1", lat); end
        axi_read(32'h10, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[4], 2'b00}) begin
            bad++; $display("[TB] FAIL basic_read: got %h/%b, required %h/00", data, resp, ref_mem[4]);
        end
        total++;
        if (lat != 0) begin bad++; $display("[TB] FAIL basic_r_latency: got %0d, required 0", lat); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] data; int lat; int cyc;
        s_WVALID = 1'b1; s_WDATA = 32'h0000_1234; s_WSTRB = 4'h3;
        @(posedge clk); #1;
        s_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({s_AWREADY, s_WREADY, s_BVALID} !== 3'b100) begin
                bad++; $display("[TB] FAIL w_first_ready c%0d: got %b, required 100", i, {s_AWREADY, s_WREADY, s_BVALID});
            end
            if (i < 2) begin @(posedge clk); #1; end
        end
        s_AWVALID = 1'b1; s_AWADDR = 32'h10; s_AWPROT = 3'b001;
        @(posedge clk); #1;
        s_AWVALID = 1'b0;
        s_BREADY = 1'b1;
        cyc = 0;
        while (!s_BVALID && cyc < 50) begin @(posedge clk); #1; cyc++; end
        resp = s_BRESP;
        total++;
        if ({s_BVALID, resp} !== 3'b100) begin
            bad++; $display("[TB] FAIL w_first_bresp: got %b/%b, required 1/00", s_BVALID, resp);
        end
        @(posedge clk); #1;
        s_BREADY = 1'b0;
        model_write(32'h10, 32'h0000_1234, 4'h3, 3'b001);
        axi_read(32'h10, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[4], 2'b00} || data !== 32'hDEAD1234) begin
            bad++; $display("[TB] FAIL w_first_readback: got %h/%b, required DEAD1234/00", data, resp);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] data; int lat;
        axi_write(32'h0, 32'h0BAD_F00D, 4'hF, 3'b001, 0, 1, resp, lat);
        model_write(32'h0, 32'h0BAD_F00D, 4'hF, 3'b001);
        axi_write(32'hFFC, 32'h7777_8888, 4'hF, 3'b011, 1, 0, resp, lat);
        model_write(32'hFFC, 32'h7777_8888, 4'hF, 3'b011);
        total++;
        if (resp !== 2'b00) begin bad++; $display("[TB] FAIL last_word_bresp: got %b, required 00", resp); end
        axi_write(32'h1000, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0, resp, lat);
        total++;
        if (resp !== 2'b11) begin bad++; $display("[TB] FAIL oor_bresp: got %b, required 11", resp); end
        axi_read(32'h1000, data, resp, lat);
        total++;
        if ({data, resp} !== {32'h0, 2'b11}) begin
            bad++; $display("[TB] FAIL oor_read: got %h/%b, required 00000000/11", data, resp);
        end
        axi_read(32'h0, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[0], 2'b00}) begin
            bad++; $display("[TB] FAIL oor_no_alias: got %h/%b, required %h/00", data, resp, ref_mem[0]);
        end
        axi_read(32'hFFE, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[1023], 2'b00}) begin
            bad++; $display("[TB] FAIL last_word_read: got %h/%b, required %h/00", data, resp, ref_mem[1023]);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [31:0] data; int lat;
        s_ARVALID = 1'b1; s_ARADDR = 32'h13; s_RREADY = 1'b0;
        @(posedge clk); #1;
        s_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({s_RVALID, s_ARREADY, s_RRESP, s_RDATA} !== {1'b1, 1'b0, 2'b00, ref_mem[4]}) begin
                bad++; $display("[TB] FAIL r_stall c%0d: got %b %b %b %h, required 1 0 00 %h",
                                i, s_RVALID, s_ARREADY, s_RRESP, s_RDATA, ref_mem[4]);
            end
            @(posedge clk); #1;
        end
        s_RREADY = 1'b1;
        @(posedge clk); #1;
        s_RREADY = 1'b0;
        total++;
        if ({s_RVALID, s_ARREADY} !== 2'b01) begin
            bad++; $display("[TB] FAIL r_retire: got %b, required 01", {s_RVALID, s_ARREADY});
        end
        s_AWVALID = 1'b1; s_AWADDR = 32'h20; s_AWPROT = 3'b001;
        s_WVALID = 1'b1; s_WDATA = 32'h5566_7788; s_WSTRB = 4'hF; s_BREADY = 1'b0;
        @(posedge clk); #1;
        s_AWVALID = 1'b0; s_WVALID = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({s_BVALID, s_BRESP, s_AWREADY, s_WREADY} !== 5'b10000) begin
                bad++; $display("[TB] FAIL b_stall c%0d: got %b, required 10000", i, {s_BVALID, s_BRESP, s_AWREADY, s_WREADY});
            end
            @(posedge clk); #1;
        end
        s_BREADY = 1'b1;
        @(posedge clk); #1;
        s_BREADY = 1'b0;
        total++;
        if ({s_BVALID, s_AWREADY, s_WREADY} !== 3'b011) begin
            bad++; $display("[TB] FAIL b_retire: got %b, required 011", {s_BVALID, s_AWREADY, s_WREADY});
        end
        model_write(32'h20, 32'h5566_7788, 4'hF, 3'b001);
        axi_read(32'h20, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[8], 2'b00}) begin
            bad++; $display("[TB] FAIL b_stall_readback: got %h/%b, required %h/00", data, resp, ref_mem[8]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] data; int lat;
        axi_write(32'h40, 32'hA5A5_A5A5, 4'hF, 3'b001, 0, 0, resp, lat);
        model_write(32'h40, 32'hA5A5_A5A5, 4'hF, 3'b001);
        s_AWVALID = 1'b1; s_AWADDR = 32'h40; s_AWPROT = 3'b001;
        @(posedge clk); #1;
        s_AWVALID = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID} !== 5'b0) begin
            bad++; $display("[TB] FAIL mid_reset_flags: got %b, required 00000",
                            {s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_WVALID = 1'b1; s_WDATA = 32'h1111_1111; s_WSTRB = 4'hF;
        @(posedge clk); #1;
        s_WVALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s_BVALID !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_reset_no_resp: got bvalid=%b, required 0", s_BVALID);
        end
        axi_read(32'h40, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[16], 2'b00}) begin
            bad++; $display("[TB] FAIL mid_reset_contents: got %h/%b, required %h/00", data, resp, ref_mem[16]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        axi_read(32'h10, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[4], 2'b00}) begin
            bad++; $display("[TB] FAIL reset_keeps_memory: got %h/%b, required %h/00", data, resp, ref_mem[4]);
        end
    endtask

    task automatic test_read_during_write();
        logic [1:0] resp; logic [31:0] data; int lat;
        axi_write(32'h80, 32'h0102_0304, 4'hF, 3'b001, 0, 0, resp, lat);
        model_write(32'h80, 32'h0102_0304, 4'hF, 3'b001);
        s_AWVALID = 1'b1; s_AWADDR = 32'h80; s_AWPROT = 3'b001;
        s_WVALID = 1'b1; s_WDATA = 32'hCAFE_F00D; s_WSTRB = 4'hF; s_BREADY = 1'b0;
        @(posedge clk); #1;
        s_AWVALID = 1'b0; s_WVALID = 1'b0;
        s_ARVALID = 1'b1; s_ARADDR = 32'h80; s_RREADY = 1'b0;
        @(posedge clk); #1;
        s_ARVALID = 1'b0;
        total++;
        if ({s_RVALID, s_BVALID, s_RDATA} !== {2'b11, ref_mem[32]}) begin
            bad++; $display("[TB] FAIL read_during_write: got %b %b %h, required 1 1 %h",
                            s_RVALID, s_BVALID, s_RDATA, ref_mem[32]);
        end
        s_RREADY = 1'b1; s_BREADY = 1'b1;
        @(posedge clk); #1;
        s_RREADY = 1'b0; s_BREADY = 1'b0;
        model_write(32'h80, 32'hCAFE_F00D, 4'hF, 3'b001);
        axi_read(32'h80, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[32], 2'b00}) begin
            bad++; $display("[TB] FAIL after_rdw_readback: got %h/%b, required %h/00", data, resp, ref_mem[32]);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [31:0] addr, wdata, data; logic [3:0] strb; logic [2:0] prot;
        int lat, idx;
        for (int i = 0; i < 32; i++) begin
            wdata = $urandom;
            axi_write(32'(i * 4), wdata, 4'hF, 3'b001, 0, 0, resp, lat);
            model_write(32'(i * 4), wdata, 4'hF, 3'b001);
        end
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) == 0)
                addr = MEM_BYTES + 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
            else
                addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wdata = $urandom;
                strb  = 4'($urandom_range(0, 15));
                prot  = 3'($urandom_range(0, 7));
                axi_write(addr, wdata, strb, prot, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
                total++;
                if (resp !== exp_wresp(addr, prot)) begin
                    bad++; $display("[TB] FAIL rand_bresp #%0d addr=%h prot=%b: got %b, required %b",
                                    n, addr, prot, resp, exp_wresp(addr, prot));
                end
                model_write(addr, wdata, strb, prot);
            end else begin
                axi_read(addr, data, resp, lat);
                idx = int'(addr / 4);
                total++;
                if (addr >= MEM_BYTES) begin
                    if ({data, resp} !== {32'h0, 2'b11}) begin
                        bad++; $display("[TB] FAIL rand_oor_read #%0d addr=%h: got %h/%b, required 0/11", n, addr, data, resp);
                    end
                end else if ({data, resp} !== {ref_mem[idx], 2'b00}) begin
                    bad++; $display("[TB] FAIL rand_read #%0d addr=%h: got %h/%b, required %h/00",
                                    n, addr, data, resp, ref_mem[idx]);
                end
            end
        end
    endtask

`ifdef AXI4_LITE_RAM_PROT_EN
    task automatic test_prot();
        logic [1:0] resp; logic [31:0] data; int lat;
        axi_write(32'h100, 32'h1357_9BDF, 4'hF, 3'b001, 0, 0, resp, lat);
        model_write(32'h100, 32'h1357_9BDF, 4'hF, 3'b001);
        total++;
        if (resp !== 2'b00) begin bad++; $display("[TB] FAIL prot_priv_bresp: got %b, required 00", resp); end
        axi_write(32'h100, 32'hFFFF_0000, 4'hF, 3'b000, 0, 0, resp, lat);
        total++;
        if (resp !== 2'b10) begin bad++; $display("[TB] FAIL prot_unpriv_bresp: got %b, required 10", resp); end
        axi_read(32'h100, data, resp, lat);
        total++;
        if ({data, resp} !== {ref_mem[64], 2'b00}) begin
            bad++; $display("[TB] FAIL prot_unchanged: got %h/%b, required %h/00", data, resp, ref_mem[64]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 32'h0;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_read_during_write();
`ifdef AXI4_LITE_RAM_PROT_EN
        test_prot();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi4_lite_ram_ctrl.md
AXI4_LITE_RAM_CTRL -- requirements
Module: axi4_lite_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 or 64 legal.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DATA_WIDTH words; power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0; DEPTH*DATA_WIDTH/8 aligned.
REQ-005 SHALL have ports:
- iCLK  in  1  clock.
- iRST  in  1  reset; one clock; reset is asynchronous and active-high.
- s_AW{VALID,PROT,ADDR} in 1/3/ADDR_WIDTH, s_AWREADY out 1: write-address channel.
- s_W{VALID,DATA,STRB} in 1/DATA_WIDTH/DATA_WIDTH/8, s_WREADY out 1: write-data channel.
- s_BREADY in 1, s_BVALID out 1, s_BRESP out 2: write-response channel.
- s_AR{VALID,PROT,ADDR} in 1/3/ADDR_WIDTH, s_ARREADY out 1: read-address channel.
- s_RREADY in 1, s_RVALID out 1, s_RRESP out 2, s_RDATA out DATA_WIDTH: read-data channel.

Function
REQ-006 SHALL decode index = (ADDR-BASE_ADDR)>>log2(DATA_WIDTH/8); in range iff ADDR>=BASE_ADDR and index<DEPTH; low byte-offset bits ignored.
REQ-007 SHALL accept AW and W independently, in either order or the same cycle, each latched in its own holding register.
REQ-008 SHALL drive s_AWREADY high iff no AW held and s_BVALID low; s_WREADY likewise for W.
REQ-009 Write FSM SHALL be W_IDLE -> (AW only) W_HAVE_A / (W only) W_HAVE_D / (both) W_COMMIT; W_HAVE_x -> W_COMMIT on the missing handshake; W_COMMIT -> W_RESP after one cycle; W_RESP -> W_IDLE on s_BREADY.
REQ-010 In W_COMMIT SHALL write bytes with WSTRB[i]=1 to an in-range index; BVALID SHALL be high the cycle after W_COMMIT with BRESP OKAY (2'b00).
REQ-011 Out-of-range write SHALL leave memory unchanged and return BRESP DECERR (2'b11).
REQ-012 WSTRB=0 SHALL change no byte and return OKAY.
REQ-013 s_BVALID/s_BRESP SHALL hold stable until s_BREADY handshake.
REQ-014 s_ARREADY SHALL be high iff s_RVALID low (one outstanding read).
REQ-015 After AR handshake at edge N, s_RVALID SHALL be high from edge N+1 with s_RDATA/s_RRESP held stable until s_RREADY handshake; RVALID and RREADY in same cycle retire the beat, allowing ARREADY next cycle.
REQ-016 Out-of-range read SHALL return s_RDATA=0, RRESP DECERR.
REQ-017 Read sampling the array on the same edge as a W_COMMIT write to the same index SHALL return pre-write data.
REQ-018 Read and write channels SHALL operate concurrently with no mutual stalls.

Reset
REQ-019 While iRST high: s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RVALID = 0; s_BRESP, s_RRESP, s_RDATA = 0; FSMs at W_IDLE/R_IDLE; holding registers cleared.
REQ-020 Reset mid-transaction SHALL discard pending transactions without any memory write; memory contents SHALL NOT be cleared.
REQ-021 READY outputs SHALL rise in the first cycle after iRST deasserts.

Configuration
REQ-022 With AXI4_LITE_RAM_PROT_EN defined, a write whose AWPROT[0]=0 (unprivileged) SHALL not modify memory and SHALL return BRESP SLVERR (2'b10); reads unaffected.
REQ-023 Without AXI4_LITE_RAM_PROT_EN, AWPROT and ARPROT SHALL be ignored.

Structure
REQ-024 Response codes OKAY/EXOKAY/SLVERR/DECERR and write/read FSM state encodings SHALL live in shared package axi4_lite_pkg.
REQ-025 Storage SHALL be sub-module axi4_lite_ram_array: one synchronous write port with byte enables, one synchronous read port, DEPTH x DATA_WIDTH, no reset.

Verification
REQ-026 AW+W same cycle, addr 0x10, data 0xDEADBEEF, strb 0xF, BREADY=1 -> BVALID 2 cycles later, BRESP=00; read 0x10 -> RDATA 0xDEADBEEF, RRESP=00 one cycle after AR.
REQ-027 W three cycles before AW, strb 0x3, data 0x1234 to word holding 0xDEADBEEF -> readback 0xDEAD1234; AWREADY stays high until AW arrives.
REQ-028 DEPTH=1024, write 0x1000 -> BRESP=11, no array change; read 0x1000 -> RDATA=0, RRESP=11.
REQ-029 RREADY held low 5 cycles -> RVALID, RDATA stable, ARREADY low throughout; BREADY low likewise stalls AWREADY/WREADY.
REQ-030 iRST pulsed between AW and W handshakes -> no write occurs, all VALIDs 0, prior contents intact.
REQ-031 With AXI4_LITE_RAM_PROT_EN, write AWPROT=3'b000 -> BRESP=10, memory unchanged; AWPROT=3'b001 -> OKAY and written.
